// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
// Packet locking is enabled by defining STREAM_ARB_PKT_LOCK_EN.
package stream_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index following ptr, wrapping at num_req-1 -> 0 so unused codes are never produced.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
        return ((ptr + 32'd1) >= num_req) ? 32'd0 : (ptr + 32'd1);
    endfunction

endpackage

// File: rtl/stream_arb_stage.sv
// Output register slice: holds one beat plus its requester id until downstream takes it.
// The last bit exists only when STREAM_ARB_PKT_LOCK_EN is defined.
module stream_arb_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ID_WIDTH-1:0]   i_id,
`ifdef STREAM_ARB_PKT_LOCK_EN
    input  logic                  i_last,
    output logic                  o_last,
`endif
    input  logic                  i_out_ready,
    output logic                  o_stage_ready_c,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ID_WIDTH-1:0]   o_id
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ID_WIDTH-1:0]   r_id;

    // Empty slot, or the held beat leaves on this edge: a new beat may enter without a bubble.
    assign o_stage_ready_c = ~r_valid | i_out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_id    <= i_id;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef STREAM_ARB_PKT_LOCK_EN
    logic r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b0;
        end else if (i_load) begin
            r_last <= i_last;
        end
    end

    assign o_last = r_last;
`endif

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_id    = r_id;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready streams into one registered stage.
// Define STREAM_ARB_PKT_LOCK_EN to hold a grant for a whole packet (req_last/out_last).
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef STREAM_ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_last,
    output logic                          out_last,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_WIDTH-1:0]           out_id
);

    logic [ID_WIDTH-1:0]   r_ptr;
    logic [NUM_REQ-1:0]    w_lock_mask;
    logic [NUM_REQ-1:0]    w_elig;
    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_win;
    logic                  w_stage_ready;
    logic                  w_load;
    logic                  w_adv;
    logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];
    int unsigned           w_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_elig = req_valid & w_lock_mask;

    // Rotate-priority search starting at r_ptr; wraps at NUM_REQ, not at the next power of two.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 32'd0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && w_elig[ID_WIDTH'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = ID_WIDTH'(w_idx);
            end
        end
    end

    // A granted requester is always valid, so ready on the winner is also the transfer-in strobe.
    assign w_load = w_found & w_stage_ready & ~reset;

    always_comb begin
        req_ready = '0;
        if (w_load) begin
            req_ready[w_win] = 1'b1;
        end
    end

`ifdef STREAM_ARB_PKT_LOCK_EN
    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [ID_WIDTH-1:0] r_lock_id;
    logic [ID_WIDTH-1:0] w_lock_id_nxt;
    logic                w_win_last;

    assign w_win_last = req_last[w_win];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lock_id_nxt = r_lock_id;
        case (r_state)
            IDLE: begin
                if (w_load && !w_win_last) begin
                    w_state_nxt   = LOCKED;
                    w_lock_id_nxt = w_win;
                end
            end
            LOCKED: begin
                if (w_load && w_win_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // While locked only the packet owner is eligible, even when it momentarily drops valid.
    assign w_lock_mask = (r_state == LOCKED) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_lock_id) : '1;
    assign w_adv       = w_load & w_win_last;
`else
    assign w_lock_mask = '1;
    assign w_adv       = w_load;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_adv) begin
            r_ptr <= ID_WIDTH'(rr_next(32'(w_win), NUM_REQ));
        end
    end

    stream_arb_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_stage (
        .clk             (clk),
        .reset           (reset),
        .i_load          (w_load),
        .i_data          (w_req_data[w_win]),
        .i_id            (w_win),
`ifdef STREAM_ARB_PKT_LOCK_EN
        .i_last          (w_win_last),
        .o_last          (out_last),
`endif
        .i_out_ready     (out_ready),
        .o_stage_ready_c (w_stage_ready),
        .o_valid         (out_valid),
        .o_data          (out_data),
        .o_id            (out_id)
    );

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: reference model plus directed scenarios on a 4- and a 3-requester instance.
// Packet-lock scenarios are compiled in when STREAM_ARB_PKT_LOCK_EN is defined.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int N3 = 3;
    localparam int DW = 32;

    logic            clk       = 1'b0;
    logic            reset     = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   tb_data [N];
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;

    logic [N3-1:0]    v3     = '0;
    logic [N3-1:0]    rdy3;
    logic [N3*DW-1:0] data3  = {32'h20, 32'h10, 32'h00};
    logic             ov3;
    logic [DW-1:0]    od3;
    logic [1:0]       oid3;

`ifdef STREAM_ARB_PKT_LOCK_EN
    logic [N-1:0]  req_last = '1;
    logic          out_last;
    logic [N3-1:0] last3    = '1;
    logic          olast3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = tb_data[i];
    end

    stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
`ifdef STREAM_ARB_PKT_LOCK_EN
        .req_last  (req_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    stream_rr_arbiter #(.NUM_REQ(N3), .DATA_WIDTH(DW)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (v3),
        .req_ready (rdy3),
        .req_data  (data3),
`ifdef STREAM_ARB_PKT_LOCK_EN
        .req_last  (last3),
        .out_last  (olast3),
`endif
        .out_valid (ov3),
        .out_ready (1'b1),
        .out_data  (od3),
        .out_id    (oid3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what the 4-requester arbiter must hold after each edge.
    logic          m_valid   = 1'b0;
    logic [DW-1:0] m_data    = '0;
    int            m_id      = 0;
    int            m_ptr     = 0;
    bit            m_locked  = 1'b0;
    int            m_lock_id = 0;
    bit            m_last    = 1'b0;

    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (v[2'(i)] && (!m_locked || i == m_lock_id)) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = pick(req_valid);
        if (!reset && w >= 0 && (!m_valid || out_ready)) r[2'(w)] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid  = 1'b0;
            m_data   = '0;
            m_id     = 0;
            m_ptr    = 0;
            m_locked = 1'b0;
            m_last   = 1'b0;
        end else begin
            int w;
            bit take;
            w    = pick(req_valid);
            take = (w >= 0) && (!m_valid || out_ready);
            if (take) begin
                m_valid = 1'b1;
                m_data  = tb_data[2'(w)];
                m_id    = w;
`ifdef STREAM_ARB_PKT_LOCK_EN
                m_last = req_last[2'(w)];
                if (req_last[2'(w)]) begin
                    m_locked = 1'b0;
                    m_ptr    = (w + 1) % N;
                end else begin
                    m_locked  = 1'b1;
                    m_lock_id = w;
                end
`else
                m_ptr = (w + 1) % N;
`endif
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("mdl_req_ready", 32'(req_ready), 32'(exp_ready()));
        chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
        chk("mdl_out_data", out_data, m_data);
        chk("mdl_out_id", 32'(out_id), 32'(m_id));
`ifdef STREAM_ARB_PKT_LOCK_EN
        chk("mdl_out_last", 32'(out_last), 32'(m_last));
`endif
    end

    initial begin
        for (int i = 0; i < N; i++) tb_data[i] = 32'(32'h100 * i);
        req_valid = '1;

        repeat (3) begin
            step();
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_out_id", 32'(out_id), 32'h0);
        end
        reset = 1'b0;
        #1;
        chk("first_ready", 32'(req_ready), 32'h1);

        for (int k = 0; k < 10; k++) begin
            step();
            chk("rot_valid", 32'(out_valid), 32'h1);
            chk("rot_id", 32'(out_id), 32'(k % 4));
            chk("rot_data", out_data, 32'(32'h100 * (k % 4)));
        end

        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_id", 32'(out_id), 32'h1);
            chk("bp_data", out_data, 32'h100);
            chk("bp_ready", 32'(req_ready), 32'h0);
        end
        out_ready = 1'b1;
        step();
        chk("resume_id", 32'(out_id), 32'h2);

        req_valid = '0;
        step();
        chk("drain_valid", 32'(out_valid), 32'h0);

        // ptr lands on 2 after requester 1, then only 3 and 1 compete.
        req_valid = 4'b0010;
        step();
        chk("sparse_pre_id", 32'(out_id), 32'h1);
        req_valid = 4'b1010;
        step();
        chk("sparse_id0", 32'(out_id), 32'h3);
        step();
        chk("sparse_id1", 32'(out_id), 32'h1);
        step();
        chk("sparse_id2", 32'(out_id), 32'h3);
        req_valid = '0;
        step();

`ifdef STREAM_ARB_PKT_LOCK_EN
        req_last = '0;
`endif
        req_valid = 4'b0010;
        step();
        chk("midrst_pre_id", 32'(out_id), 32'h1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        step();
        reset = 1'b0;
`ifdef STREAM_ARB_PKT_LOCK_EN
        req_last = '1;
`endif
        req_valid = 4'b1111;
        step();
        chk("midrst_first_id", 32'(out_id), 32'h0);
        req_valid = '0;
        step();

        v3 = '1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("n3_valid", 32'(ov3), 32'h1);
            chk("n3_id", 32'(oid3), 32'(k % 3));
            chk("n3_data", od3, 32'(32'h10 * (k % 3)));
        end
        v3 = '0;
        step();

`ifdef STREAM_ARB_PKT_LOCK_EN
        req_last   = '0;
        tb_data[1] = 32'hA1;
        req_valid  = 4'b0110;
        step();
        chk("lk_b1_id", 32'(out_id), 32'h1);
        chk("lk_b1_data", out_data, 32'hA1);
        tb_data[1] = 32'hA2;
        step();
        chk("lk_b2_id", 32'(out_id), 32'h1);
        chk("lk_b2_data", out_data, 32'hA2);
        req_valid = 4'b0100;
        repeat (2) begin
            step();
            chk("lk_gap_valid", 32'(out_valid), 32'h0);
            chk("lk_gap_ready", 32'(req_ready), 32'h0);
        end
        req_valid   = 4'b0110;
        tb_data[1]  = 32'hA3;
        req_last[1] = 1'b1;
        step();
        chk("lk_b3_id", 32'(out_id), 32'h1);
        chk("lk_b3_data", out_data, 32'hA3);
        chk("lk_b3_last", 32'(out_last), 32'h1);
        step();
        chk("lk_after_id", 32'(out_id), 32'h2);
        chk("lk_after_data", out_data, 32'h200);
        req_valid = '0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that lets NUM_REQ valid/ready producer streams share a single registered valid/ready pipeline stage. It picks one eligible requester per cycle, forwards that beat into an internal output register and tags it with the requester index. It sits in front of a downstream stage chain wherever several producers feed one consumer.

## Interface
Parameters:
- NUM_REQ, 4, number of requester streams (≥2)
- DATA_WIDTH, 32, payload width
- ID_WIDTH, $clog2(NUM_REQ), width of the requester index (derived, not overridden)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester valid
- req_ready  output  NUM_REQ  per-requester ready, at most one bit set
- req_data  input  NUM_REQ×DATA_WIDTH  per-requester payload, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  input  NUM_REQ  end-of-packet marker; present only with STREAM_ARB_PKT_LOCK_EN
- out_valid  output  1  registered output valid
- out_ready  input  1  downstream ready
- out_data  output  DATA_WIDTH  registered payload
- out_id  output  ID_WIDTH  index of the requester that produced out_data
- out_last  output  1  registered last; present only with STREAM_ARB_PKT_LOCK_EN

## Operation
- Output stage: valid_q/data_q/id_q(/last_q) register. stage_ready = ~valid_q | out_ready.
- Eligible set: req_valid & lock_mask. lock_mask is all ones unless locked.
- Winner: first eligible index found by searching ptr, ptr+1, …, wrapping modulo NUM_REQ. Non-power-of-two NUM_REQ wraps at NUM_REQ-1→0, never into unused codes.
- req_ready[winner] = stage_ready. All other bits are 0. If there is no eligible requester, all bits are 0.
- req_ready may depend on req_valid. Requesters must not make valid depend on ready and must hold data stable while valid & ~ready.
- Transfer in: req_valid[w] & req_ready[w]. It loads data_q, id_q=w and valid_q=1 in the same edge.
- Transfer out: out_valid & out_ready. If no transfer in happens on that edge, valid_q clears. Simultaneous in and out transfers reload the stage without a bubble.
- Pointer: on each transfer in, ptr <= (w+1) mod NUM_REQ. Otherwise ptr holds.
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,…,NUM_REQ-1,0.

## Timing
- Latency: 1 cycle from accepted input beat to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- out_valid, once high, stays high with out_data/out_id stable until out_ready.
- Reset values: out_valid=0, out_data=0, out_id=0, out_last=0, ptr=0, state=IDLE.
- req_ready is 0 while reset is asserted.
- Reset mid-operation discards the buffered beat and any packet lock. The first grant after release starts search at index 0.
- Back-pressure: when out_valid=1 and out_ready=0, all req_ready bits are 0 and ptr is frozen.

## Configuration
- STREAM_ARB_PKT_LOCK_EN defined:
  - Adds req_last/out_last and a two-state FSM (IDLE, LOCKED) with lock_id.
  - IDLE: a transfer in with last=0 goes to LOCKED with lock_id=w. A transfer with last=1 stays in IDLE.
  - LOCKED: lock_mask selects only lock_id. Others stall even if lock_id drops valid. A transfer with last=1 returns to IDLE and sets ptr <= lock_id+1.
  - ptr does not advance on non-last beats.
- STREAM_ARB_PKT_LOCK_EN undefined: no last ports and no FSM. Arbitration is per beat.

## Structure
- Package stream_arb_pkg holds the arb_state_e enum (IDLE, LOCKED) and the rr_next(ptr, NUM_REQ) wrap helper function.
- Sub-module stream_arb_stage is the output register slice (valid/data/id/last, stage_ready). The arbiter instantiates it once.
- The winner search is a combinational rotate-priority block in the top module.

## Test plan
- Reset/idle: hold reset 3 cycles with all req_valid=1 → req_ready=0, out_valid=0, out_id=0. After release, first out_id=0 appears 1 cycle after its accept.
- Rotation: NUM_REQ=4, all valid, out_ready=1 for 8 cycles, data=0x100*i → out_id 0,1,2,3,0,1,2,3 back-to-back with matching data and no bubbles.
- Back-pressure: out_ready=0 for 5 cycles with out_valid=1 → out_data/out_id stable, all req_ready=0. Releasing out_ready resumes rotation from the frozen ptr.
- Sparse/wrap: only requesters 3 and 1 valid, ptr=2 → grants 3, then 1, then 3 (wrap via 0 skipped). With NUM_REQ=3 and ptr after index 2 → next search starts at 0.
- Packet lock (macro on): requester 1 sends 3 beats (last on beat 3) while requester 2 is valid. Requester 1 drops valid for 2 cycles mid-packet → requester 2 is never granted until after beat 3, then out_id=2.
- Reset mid-packet (macro on): assert reset while LOCKED on id 1 → after release, state is IDLE and requester 0 is granted first if valid.
